// File: rtl/xbuttons_pkg.sv
// Shared constants for the push-button peripheral: bus width, register
// offsets within the peripheral and its base address on the decoder.
package xbuttons_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic BTN_LEVEL_ADDR = 1'b0;
    localparam logic BTN_EVENT_ADDR = 1'b1;

    localparam logic [31:0] BTN_BASE = 32'h0000_0040;

    typedef enum logic {
        REG_LEVEL = 1'b0,
        REG_EVENT = 1'b1
    } btn_reg_e;

endpackage

// File: rtl/xdebounce.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a
// debounce counter that only accepts a new level after it has been seen
// for DEBOUNCE_CYCLES consecutive cycles.
//   clk      system clock
//   rst      synchronous reset, active low
//   btn_i    raw asynchronous pin
//   stable_o debounced level
module xdebounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Count consecutive mismatches; any agreement restarts the count.
    always_comb begin
        sync1_d  = btn_i;
        sync2_d  = sync1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/xbuttons.sv
// Memory-mapped push-button peripheral. Debounces each pin and latches
// sticky press events (and, with BTN_RELEASE_EN defined, release events).
//   clk       system clock
//   rst       synchronous reset, active low
//   sel       peripheral select from the address decoder
//   we        write strobe, qualified by sel
//   addr      register offset: 0 = LEVEL, 1 = EVENT
//   data_in   write data (EVENT writes are write-1-to-clear)
//   data_out  read data, combinational from addr and registers
//   btn       raw button pins, active high
// Optional feature macro: BTN_RELEASE_EN adds release flags in EVENT
// bits [2*N_BTN-1:N_BTN].
module xbuttons
    import xbuttons_pkg::*;
#(
    parameter int unsigned DATA_W          = xbuttons_pkg::DATA_W,
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic              addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [N_BTN-1:0]  btn
);

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_prev_q, stable_prev_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic             rd_clr;
    logic             wr_ev;
    btn_reg_e         reg_sel;

    // One conditioner per pin.
    for (genvar gi = 0; gi < int'(N_BTN); gi++) begin : g_deb
        xdebounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn[gi]),
            .stable_o(stable[gi])
        );
    end

    assign reg_sel = btn_reg_e'(addr);
    assign rd_clr  = sel & ~we & (addr == BTN_EVENT_ADDR);
    assign wr_ev   = sel &  we & (addr == BTN_EVENT_ADDR);

    // Clears apply first so a same-cycle edge still sets the flag.
    always_comb begin
        stable_prev_d = stable;
        press_d       = press_q;
        if (rd_clr) begin
            press_d = '0;
        end else if (wr_ev) begin
            press_d = press_q & ~data_in[N_BTN-1:0];
        end
        press_d = press_d | (stable & ~stable_prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stable_prev_q <= '0;
            press_q       <= '0;
        end else begin
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
        end
    end

`ifdef BTN_RELEASE_EN
    logic [N_BTN-1:0] release_q, release_d;

    always_comb begin
        release_d = release_q;
        if (rd_clr) begin
            release_d = '0;
        end else if (wr_ev) begin
            release_d = release_q & ~data_in[2*N_BTN-1:N_BTN];
        end
        release_d = release_d | (~stable & stable_prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            release_q <= '0;
        end else begin
            release_q <= release_d;
        end
    end

    logic [DATA_W-1:0] event_word;
    assign event_word = DATA_W'({release_q, press_q});
`else
    logic [DATA_W-1:0] event_word;
    assign event_word = DATA_W'(press_q);
`endif

    // Only the low flag bits of data_in are meaningful.
    logic unused_data;
    assign unused_data = ^data_in;

    // Read mux, independent of sel; the decoder selects between peripherals.
    always_comb begin
        data_out = '0;
        case (reg_sel)
            REG_LEVEL: data_out = DATA_W'(stable);
            REG_EVENT: data_out = event_word;
            default:   data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_xbuttons.sv
module tb_xbuttons;

    localparam int unsigned DW = 32;
`ifdef BTN_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic          we;
    logic          addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [3:0]    btn;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    xbuttons #(
        .DATA_W         (DW),
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .btn     (btn)
    );

    // Monitor: every bus read presents data; pop and compare.
    always @(negedge clk) begin
        if (sel && !we) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %h, no expected value queued", data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, data_out, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic a, input logic [DW-1:0] e, input string nm);
        exp_t x;
        x.exp  = e;
        x.name = nm;
        q.push_back(x);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        sel = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [DW-1:0] d);
        sel     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        sel     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
        btn = 4'b1111;

        // Reset held for 3 edges with all buttons pressed.
        tick(1);
        rd(1'b0, 32'h0, "reset_level");
        rd(1'b1, 32'h0, "reset_event");
        rst = 1'b1;
        tick(5);
        rd(1'b0, 32'h0, "post_reset_level_5edges");
        rd(1'b0, 32'hF, "post_reset_level_6edges");
        rd(1'b1, 32'hF, "post_reset_event_7edges");
        rd(1'b1, 32'h0, "post_reset_event_cleared");

        // Release all.
        btn = 4'b0000;
        tick(8);
        rd(1'b0, 32'h0, "release_all_level");
        rd(1'b1, REL ? 32'hF0 : 32'h0, "release_all_event");

        // Clean press on btn[2].
        btn[2] = 1'b1;
        tick(5);
        rd(1'b0, 32'h0, "press2_level_5edges");
        rd(1'b0, 32'h4, "press2_level_6edges");
        rd(1'b1, 32'h4, "press2_event");
        rd(1'b1, 32'h0, "press2_event_cleared");
        btn[2] = 1'b0;
        tick(8);
        rd(1'b1, REL ? 32'h40 : 32'h0, "release2_event");

        // Bounce on btn[0]: 2-cycle pulses never settle.
        btn[0] = 1'b1; rd(1'b0, 32'h0, "bounce_a"); rd(1'b0, 32'h0, "bounce_b");
        btn[0] = 1'b0; rd(1'b0, 32'h0, "bounce_c"); rd(1'b0, 32'h0, "bounce_d");
        btn[0] = 1'b1; rd(1'b0, 32'h0, "bounce_e"); rd(1'b0, 32'h0, "bounce_f");
        btn[0] = 1'b0; rd(1'b0, 32'h0, "bounce_g"); rd(1'b0, 32'h0, "bounce_h");
        btn[0] = 1'b1;
        tick(5);
        rd(1'b0, 32'h0, "bounce_level_5edges");
        rd(1'b0, 32'h1, "bounce_level_6edges");
        rd(1'b1, 32'h1, "bounce_single_press");
        rd(1'b1, 32'h0, "bounce_event_cleared");
        btn[0] = 1'b0;
        tick(8);
        rd(1'b1, REL ? 32'h10 : 32'h0, "release0_event");

        // Read EVENT in the very cycle btn[1]'s press is accepted.
        btn[1] = 1'b1;
        tick(6);
        rd(1'b1, 32'h0, "setclr_read_during_set");
        rd(1'b1, 32'h2, "setclr_flag_survived");
        rd(1'b1, 32'h0, "setclr_cleared");
        btn[1] = 1'b0;
        tick(8);
        rd(1'b1, REL ? 32'h20 : 32'h0, "release1_event");

        // W1C with flags 1010.
        btn = 4'b1010;
        tick(8);
        wr(1'b1, 32'h2);
        rd(1'b1, 32'h8, "w1c_event");
        rd(1'b0, 32'hA, "w1c_level");
        wr(1'b0, 32'h5);
        rd(1'b0, 32'hA, "level_write_ignored");
        rd(1'b1, 32'h0, "w1c_after_read");
        btn = 4'b0000;
        tick(8);
        rd(1'b1, REL ? 32'hA0 : 32'h0, "release13_event");

        // Press then release btn[3].
        btn[3] = 1'b1;
        tick(8);
        btn[3] = 1'b0;
        tick(8);
        rd(1'b1, REL ? 32'h88 : 32'h08, "press_release3_event");
        rd(1'b1, 32'h0, "press_release3_cleared");

        tick(2);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
